fp_add_arbiter: RTL and testbench

- Shares one floating-point add unit (adder datapath plus its start/done control FSM) between NREQ requesters.
- Round-robin arbitration; a valid/ready handshake on the request side and a one-cycle response pulse on the response side.
- Sequences the unit's level-sensitive start/done protocol, captures the result and returns it to the granted requester.
- A watchdog timeout protects the system against a hung unit.

---
 rtl/fp_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/fp_add_arbiter.sv | 91 +++++++++
 tb/tb_fp_add_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for arbitrated floating-point units: widths, default
// watchdog limit and the request/response sequencer state encoding.
package fp_pkg;
  localparam int FP_W        = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_DONE = 2'b01,
    RELEASE   = 2'b10,
    RESP      = 2'b11
  } fsm_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin grant; scanning starts just after the
// previously granted requester so every requester is reached within NREQ turns.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [LW-1:0]   grant_idx
);
  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one FP add unit between NREQ requesters: round-robin accept, drive the
// level start/done handshake, return the result (or a timeout error) as a pulse.
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = FP_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][W-1:0]   req_a,
  input  logic [NREQ-1:0][W-1:0]   req_b,
  output logic [NREQ-1:0]          resp_valid,
  output logic [W-1:0]             resp_data,
  output logic                     resp_err,
  output logic                     fpu_start,
  output logic [W-1:0]             fpu_a,
  output logic [W-1:0]             fpu_b,
  input  logic                     fpu_done,
  input  logic [W-1:0]             fpu_result
);
  localparam int LW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  fsm_state_e      state;
  logic [LW-1:0]   last, gsel, grant_idx;
  logic [NREQ-1:0] grant;
  logic [CW-1:0]   cnt;

  rr_arbiter #(.NREQ(NREQ), .LW(LW)) u_rr (
    .req       (req_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = (state == IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fpu_start  <= 1'b0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
      last       <= LW'(NREQ - 1);
      gsel       <= '0;
    end else begin
      resp_valid <= '0;
      unique case (state)
        IDLE: if (|grant) begin
          fpu_a     <= req_a[grant_idx];
          fpu_b     <= req_b[grant_idx];
          gsel      <= grant_idx;
          last      <= grant_idx;
          fpu_start <= 1'b1;
          cnt       <= '0;
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
          // done takes precedence over a watchdog expiry in the same cycle
          if (fpu_done) begin
            resp_data <= fpu_result;
            resp_err  <= 1'b0;
            fpu_start <= 1'b0;
            state     <= RELEASE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            fpu_start <= 1'b0;
            state     <= RELEASE;
          end
        end
        // the unit is only reusable once it has dropped done
        RELEASE: if (!fpu_done) state <= RESP;
        RESP: begin
          resp_valid[gsel] <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter with a behavioural add unit whose done
// latency and done-hold time are set per operation.
module tb_fp_add_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int TMO  = 16;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;
  localparam logic [31:0] F5 = 32'h40A00000;
  localparam logic [31:0] F6 = 32'h40C00000;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid, req_ready, resp_valid;
  logic [NREQ-1:0][W-1:0] req_a, req_b;
  logic [W-1:0]           resp_data, fpu_a, fpu_b, fpu_result;
  logic                   resp_err, fpu_start, fpu_done;

  fp_add_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic real s2r(input logic [31:0] x);
    real m;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    m = m * (2.0 ** real'(int'(x[30:23]) - 127));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int          ex;
    if (r == 0.0) return '0;
    d  = $realtobits(r);
    ex = int'(d[62:52]) - 896;
    return {d[63], ex[7:0], d[51:29]};
  endfunction

  // add unit: done rises so that start is seen high mk cycles (mk=0: never),
  // then done stays up mhold extra cycles after start falls
  logic mdone;
  int   scnt, hcnt, mk, mhold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdone <= 1'b0; scnt <= 0; hcnt <= 0;
    end else if (fpu_start) begin
      hcnt <= 0;
      if (mk >= 2 && scnt == mk - 2) mdone <= 1'b1;
      else if (!mdone) scnt <= scnt + 1;
    end else if (mdone) begin
      if (hcnt == mhold) begin mdone <= 1'b0; scnt <= 0; end
      else hcnt <= hcnt + 1;
    end else scnt <= 0;
  end
  assign fpu_done = mdone;
  always_comb fpu_result = mdone ? r2s(s2r(fpu_a) + s2r(fpu_b)) : '0;

  typedef struct { int idx; logic [31:0] data; logic err; } exp_t;
  exp_t sbq[$];
  int   nresp = 0, resp_cyc = 0;
  logic [NREQ-1:0] prev_rv = '0;

  always @(negedge clk) begin
    exp_t e;
    logic [NREQ-1:0] ev;
    if (resp_valid != '0) begin
      chk("resp_pulse_width", 32'(prev_rv), 0);
      chk("resp_onehot", 32'($onehot(resp_valid)), 1);
      if (sbq.size() == 0) chk("resp_unexpected", 32'(resp_valid), 0);
      else begin
        e  = sbq.pop_front();
        ev = '0;
        ev[e.idx] = 1'b1;
        chk("resp_idx", 32'(resp_valid), 32'(ev));
        chk("resp_data", resp_data, e.data);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
      nresp++;
      resp_cyc = cyc;
    end
    prev_rv = resp_valid;
  end

  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input int k, input int hold, input logic [31:0] ed, input logic ee,
                        input int est, input int elat, input bit stab);
    int t, acc, st, r0;
    mk = k; mhold = hold;
    req_a[idx] = a; req_b[idx] = b; req_valid[idx] = 1'b1;
    sbq.push_back('{idx: idx, data: ed, err: ee});
    #1;
    t = 0;
    while (!req_ready[idx] && t < 100) begin @(negedge clk); #1; t++; end
    chk("accept", 32'(req_ready[idx]), 1);
    acc = cyc + 1;
    st = 0; r0 = nresp; t = 0;
    do begin
      @(negedge clk); #1;
      if (t == 0) req_valid[idx] = 1'b0;
      if (fpu_start) st++;
      if (stab && nresp == r0) begin
        chk("fpu_a_stable", fpu_a, a);
        chk("fpu_b_stable", fpu_b, b);
      end
      t++;
    end while (nresp == r0 && t < 300);
    chk("resp_seen", nresp - r0, 1);
    chk("start_cycles", st, est);
    chk("latency", resp_cyc - acc, elat);
  endtask

  initial begin
    int t, nacc, r0;
    logic [NREQ-1:0] eg;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; mk = 0; mhold = 0;
    req_a[0] = F1; req_b[0] = F1; req_a[1] = F5; req_b[1] = F1;
    req_valid = 2'b11;
    repeat (2) @(negedge clk); #1;
    chk("rst_start", 32'(fpu_start), 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_b", fpu_b, 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_ready_prio", 32'(req_ready), 32'h1);

    // simultaneous requests from reset, continued as a 6-op fairness run
    for (int i = 0; i < 6; i++)
      sbq.push_back('{idx: i % 2, data: (i % 2 == 0) ? F2 : F6, err: 1'b0});
    mk = 5;
    rst_n = 1'b1;
    nacc = 0; t = 0;
    while (nacc < 6 && t < 600) begin
      if (|(req_ready & req_valid)) begin
        eg = (nacc % 2 == 0) ? 2'b01 : 2'b10;
        chk("grant_order", 32'(req_ready), 32'(eg));
        nacc++;
      end
      @(negedge clk); #1;
      if (nacc == 6) req_valid = '0;
      t++;
    end
    chk("fair_accepts", nacc, 6);
    t = 0;
    while (nresp < 6 && t < 300) begin @(negedge clk); #1; t++; end
    chk("fair_resps", nresp, 6);

    // single request, 1.0 + 2.0
    run_op(0, F1, F2, 5, 0, F3, 1'b0, 5, 8, 1'b0);
    // watchdog: never done, done coinciding with expiry, done one cycle late
    run_op(1, F1, F1, 0, 0, 32'h0, 1'b1, TMO, TMO + 2, 1'b0);
    run_op(0, F2, F2, TMO, 0, F4, 1'b0, TMO, TMO + 3, 1'b0);
    run_op(1, F1, F1, TMO + 1, 0, 32'h0, 1'b1, TMO, TMO + 3, 1'b0);
    run_op(1, F5, F1, 5, 0, F6, 1'b0, 5, 8, 1'b0);

    // done held after start falls; a request withdrawn while busy is never issued
    fork
      run_op(0, F2, F1, 5, 3, F3, 1'b0, 5, 11, 1'b1);
      begin
        repeat (3) @(negedge clk);
        #1 req_a[1] = F4; req_b[1] = F4; req_valid[1] = 1'b1;
        @(negedge clk);
        #1 req_valid[1] = 1'b0;
      end
    join
    repeat (25) @(negedge clk); #1;
    chk("withdrawn_not_issued", 32'(fpu_start), 0);

    // reset in the middle of WAIT_DONE
    mk = 0; mhold = 0;
    req_a[0] = F1; req_b[0] = F2; req_valid = 2'b01;
    #1;
    t = 0;
    while (!req_ready[0] && t < 100) begin @(negedge clk); #1; t++; end
    @(negedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk); #1;
    chk("pre_rst_start", 32'(fpu_start), 1);
    r0 = nresp;
    rst_n = 1'b0;
    #1;
    chk("midrst_start", 32'(fpu_start), 0);
    chk("midrst_resp_valid", 32'(resp_valid), 0);
    chk("midrst_fpu_a", fpu_a, 0);
    req_valid = 2'b11;
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_prio", 32'(req_ready), 32'h1);
    req_valid = '0;
    repeat (25) @(negedge clk); #1;
    chk("midrst_no_resp", nresp - r0, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
